// File: rtl/banked_sram_ctl.sv
// Banked single-port SRAM with valid/ready requests, byte-enable writes,
// a pipelined read path of RD_LAT cycles and an optional post-reset clear.
// Address: low BANK_W bits pick the bank, the remaining high bits pick the row.

module banked_sram_bank #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  localparam int ROW_W = $clog2(DEPTH),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write and registered read; the port never does both at once.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++)
        if (be_i[i]) mem_q[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[row_i];
  end

  assign rdata_o = rdata_q;
endmodule

module banked_sram_ctl #(
  parameter int DATA_W       = 64,
  parameter int BANKS        = 32,
  parameter int BANK_DEPTH   = 4096,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1,
  localparam int BANK_W = $clog2(BANKS),
  localparam int ROW_W  = $clog2(BANK_DEPTH),
  localparam int ADDR_W = BANK_W + ROW_W,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o
);
  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e                        state_q, state_d;
  logic [ROW_W-1:0]              cnt_q, cnt_d;
  logic                          ready_q, ready_d;
  logic                          busy_q, busy_d;
  logic                          clr_en, clr_we;
  logic                          acc, acc_wr, acc_rd;
  logic [BANK_W-1:0]             bank, sel_q;
  logic [ROW_W-1:0]              row, bk_row;
  logic [BE_W-1:0]               bk_be;
  logic [DATA_W-1:0]             bk_wdata, rd_mux, pipe_last, rdata_q;
  logic [BANKS-1:0][DATA_W-1:0]  bank_rd;
  logic [RD_LAT:0]               vld_pipe_q;

  // Clear walks every row once; ready/busy are registered from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + ROW_W'(1);
        if (cnt_q == ROW_W'(BANK_DEPTH - 1)) state_d = S_IDLE;
      end
      default: ;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_CLEAR);
  end

  // State, clear counter and handshake registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_ON_RST != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Nothing touches memory or the read pipe on a reset cycle.
  assign clr_we = clr_en && !rst;
  assign acc    = req_valid_i && ready_q && !rst;
  assign acc_wr = acc && req_we_i;
  assign acc_rd = acc && !req_we_i;
  assign bank   = req_addr_i[BANK_W-1:0];
  assign row    = req_addr_i[ADDR_W-1:BANK_W];

  assign bk_be    = clr_we ? {BE_W{1'b1}} : req_be_i;
  assign bk_row   = clr_we ? cnt_q : row;
  assign bk_wdata = clr_we ? '0 : req_wdata_i;

  genvar b;
  for (b = 0; b < BANKS; b++) begin : g_bank
    logic hit;
    assign hit = (bank == BANK_W'(b));
    banked_sram_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH)) u_bank (
      .clk     (clk),
      .we_i    (clr_we | (acc_wr & hit)),
      .be_i    (bk_be),
      .row_i   (bk_row),
      .wdata_i (bk_wdata),
      .re_i    (acc_rd & hit),
      .rdata_o (bank_rd[b])
    );
  end

  // Remember which bank holds the freshly sampled read word.
  always_ff @(posedge clk) begin
    if (acc_rd) sel_q <= bank;
  end

  assign rd_mux = bank_rd[sel_q];

  // Data stages between the bank output and the response register.
  if (RD_LAT == 1) begin : g_lat1
    assign pipe_last = rd_mux;
  end else begin : g_latn
    logic [RD_LAT-2:0][DATA_W-1:0] dq;
    // Delay line carrying read data alongside its valid bit.
    always_ff @(posedge clk) begin
      dq[0] <= rd_mux;
      for (int k = 1; k < RD_LAT - 1; k++) dq[k] <= dq[k-1];
    end
    assign pipe_last = dq[RD_LAT-2];
  end

  // Bit 0 marks a read sampled at the last edge; bit RD_LAT is the response.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], acc_rd};
  end

  // Response data holds its last value between reads.
  always_ff @(posedge clk) begin
    if (rst)                         rdata_q <= '0;
    else if (vld_pipe_q[RD_LAT-1])   rdata_q <= pipe_last;
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = vld_pipe_q[RD_LAT];
  assign rsp_rdata_o = rdata_q;
endmodule

// File: tb/tb_banked_sram_ctl.sv
// Bench for banked_sram_ctl: table vectors, hand sequences for clear/reset
// corners, and random traffic checked against a behavioural memory model.

module tb_banked_sram_ctl;
  localparam int DW = 64, NB = 4, BD = 16, LAT = 2, AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, vld, we, rdy, rsp_v, busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [7:0]    be;

  logic          rst2, vld2, we2, rdy2, rsp_v2, busy2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wdata2, rdata2;
  logic [7:0]    be2;

  banked_sram_ctl #(.DATA_W(DW), .BANKS(NB), .BANK_DEPTH(BD), .RD_LAT(LAT), .CLEAR_ON_RST(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid_i(vld), .req_ready_o(rdy), .req_we_i(we),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
    .rsp_valid_o(rsp_v), .rsp_rdata_o(rdata), .busy_o(busy));

  banked_sram_ctl #(.DATA_W(DW), .BANKS(NB), .BANK_DEPTH(BD), .RD_LAT(1), .CLEAR_ON_RST(0)) u_dut2 (
    .clk(clk), .rst(rst2), .req_valid_i(vld2), .req_ready_o(rdy2), .req_we_i(we2),
    .req_addr_i(addr2), .req_wdata_i(wdata2), .req_be_i(be2),
    .rsp_valid_o(rsp_v2), .rsp_rdata_o(rdata2), .busy_o(busy2));

  // Behavioural model: flat memory, clear countdown, queue of due responses.
  typedef struct {int due; logic [DW-1:0] data;} rsp_t;
  logic [DW-1:0] mdl_mem [64];
  rsp_t          pend[$];
  int            clear_left, cyc;
  logic          m_ready, m_busy;
  logic [DW-1:0] m_last;
  int            n_tests, n_fail;

  typedef struct {
    bit v; bit w; logic [AW-1:0] a; logic [DW-1:0] d; logic [7:0] b;
    bit ev; logic [DW-1:0] ed;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [7:0] b);
    vld = v; we = w; addr = a; wdata = d; be = b;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    logic ev;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_ready = 1'b0; m_busy = 1'b1; clear_left = BD; m_last = '0;
      pend.delete();
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) begin
        m_ready = 1'b1; m_busy = 1'b0;
        foreach (mdl_mem[i]) mdl_mem[i] = '0;
      end
    end else if (vld) begin
      if (we) begin
        for (int i = 0; i < 8; i++)
          if (be[i]) mdl_mem[addr][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        pend.push_back('{cyc + LAT, mdl_mem[addr]});
      end
    end
    #1;
    ev = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1'b1;
      m_last = pend[0].data;
      void'(pend.pop_front());
    end
    chk("rsp_valid", {63'd0, rsp_v}, {63'd0, ev});
    chk("rsp_rdata", rdata, m_last);
    chk("req_ready", {63'd0, rdy}, {63'd0, m_ready});
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
  endtask

  // Count observed busy cycles (bounded) and any responses seen meanwhile.
  task automatic clear_len(output int nb, output int nv);
    nb = 0; nv = 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      nb++;
      step();
      if (rsp_v === 1'b1) nv++;
    end
  endtask

  task automatic read_zero_sweep(input int n);
    for (int a = 0; a < n; a++) begin
      drive(1, 0, AW'(a), '0, '0);
      step();
    end
    drive(0, 0, '0, '0, '0);
    for (int k = 0; k < LAT; k++) step();
  endtask

  initial begin
    int nb, nv;
    n_tests = 0; n_fail = 0; cyc = 0;
    clear_left = BD; m_ready = 1'b0; m_busy = 1'b1; m_last = '0;
    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    rst = 1'b1; rst2 = 1'b1;
    drive(0, 0, '0, '0, '0);
    vld2 = 0; we2 = 0; addr2 = '0; wdata2 = '0; be2 = '0;

    // Reset for two cycles, then the 16-cycle clear.
    step(); step();
    rst = 1'b0;
    clear_len(nb, nv);
    chk("clear_cycles", 64'(nb), 64'd16);
    read_zero_sweep(64);

    // Write/read latency, bank isolation, byte enables, be=0 no-op.
    tbl[0] = '{1, 1, 6'h05, 64'h0123456789ABCDEF, 8'hFF, 0, 64'h0};
    tbl[1] = '{1, 0, 6'h05, 64'h0, 8'h00, 0, 64'h0};
    tbl[2] = '{1, 0, 6'h06, 64'h0, 8'h00, 0, 64'h0};
    tbl[3] = '{0, 0, 6'h00, 64'h0, 8'h00, 1, 64'h0123456789ABCDEF};
    tbl[4] = '{1, 1, 6'h05, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1, 64'h0};
    tbl[5] = '{1, 0, 6'h05, 64'h0, 8'h00, 0, 64'h0};
    tbl[6] = '{1, 1, 6'h05, 64'hAAAAAAAAAAAAAAAA, 8'h00, 0, 64'h0};
    tbl[7] = '{1, 0, 6'h05, 64'h0, 8'h00, 1, 64'h01234567FFFFFFFF};
    tbl[8] = '{0, 0, 6'h00, 64'h0, 8'h00, 0, 64'h01234567FFFFFFFF};
    tbl[9] = '{0, 0, 6'h00, 64'h0, 8'h00, 1, 64'h01234567FFFFFFFF};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b);
      step();
      chk($sformatf("vec%0d_valid", i), {63'd0, rsp_v}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].ed);
    end

    // Back-to-back reads return in order with no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, AW'(i), 64'h100 + 64'(i), 8'hFF);
      step();
    end
    for (int i = 0; i < 8 + LAT; i++) begin
      if (i < 8) drive(1, 0, AW'(i), '0, '0);
      else       drive(0, 0, '0, '0, '0);
      step();
      if (i >= LAT) begin
        chk("b2b_valid", {63'd0, rsp_v}, 64'd1);
        chk("b2b_rdata", rdata, 64'h100 + 64'(i - LAT));
      end
    end
    drive(0, 0, '0, '0, '0);
    step();

    // Reset right after a read accept drops that read and restarts the clear.
    drive(1, 0, 6'h03, '0, '0);
    step();
    rst = 1'b1; drive(0, 0, '0, '0, '0);
    step();
    rst = 1'b0;
    clear_len(nb, nv);
    chk("midread_clear_cycles", 64'(nb), 64'd16);
    chk("dropped_read", 64'(nv), 64'd0);
    read_zero_sweep(8);

    // Reset when the clear counter reaches row 9 restarts a full clear.
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 9; k++) step();
    rst = 1'b1; step(); rst = 1'b0;
    clear_len(nb, nv);
    chk("midclear_cycles", 64'(nb), 64'd16);

    // Random traffic with rare resets; requests during clear must be ignored.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom),
            {$urandom, $urandom}, 8'($urandom));
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; drive(0, 0, '0, '0, '0);
    for (int k = 0; k < BD + LAT + 2; k++) step();

    // No-clear variant with single-cycle read latency.
    chk("d2_reset_ready", {63'd0, rdy2}, 64'd0);
    chk("d2_reset_busy", {63'd0, busy2}, 64'd0);
    chk("d2_reset_rsp_valid", {63'd0, rsp_v2}, 64'd0);
    rst2 = 1'b0;
    step();
    chk("d2_ready_first", {63'd0, rdy2}, 64'd1);
    vld2 = 1; we2 = 1; addr2 = 6'h3F; wdata2 = 64'hDEADBEEFCAFEF00D; be2 = 8'hFF;
    step();
    we2 = 0; wdata2 = '0;
    step();
    chk("d2_rsp_early", {63'd0, rsp_v2}, 64'd0);
    vld2 = 0;
    step();
    chk("d2_rsp_valid", {63'd0, rsp_v2}, 64'd1);
    chk("d2_rsp_rdata", rdata2, 64'hDEADBEEFCAFEF00D);
    step();
    chk("d2_rsp_pulse", {63'd0, rsp_v2}, 64'd0);
    chk("d2_rdata_hold", rdata2, 64'hDEADBEEFCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
